// File: rtl/sram_responder.sv
// sram_responder: cycle-based responder for an asynchronous-mode pseudo-SRAM bus.
// All sram_* pins pass through one sample stage; a single FSM sequences reads
// (programmable latency, registered read data driven onto the shared bus) and
// writes (address/data/lanes tracked while held, committed one cycle later).
// Optional feature: define SRAM_RESPONDER_CRE_EN to add the bus configuration
// register (BCR), loaded by CRE write cycles; a nonzero BCR[2:0] overrides RD_LAT.
module sram_responder #(
    parameter int ADDR_W = 12,
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sram_clk,
    input  logic        sram_adv,
    input  logic        sram_cre,
    input  logic        sram_ce,
    input  logic        sram_oe,
    input  logic        sram_we,
    input  logic        sram_lb,
    input  logic        sram_ub,
    input  logic [23:1] sram_addr,
    inout  wire  [15:0] sram_data,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DRIVE,
        WR_HOLD,
        WR_COMMIT
    } state_t;

    localparam logic [2:0] LP_RD_LAT = 3'(RD_LAT);

    // Sampled bus pins; decode only ever looks at these.
    logic        r_ce;
    logic        r_oe;
    logic        r_we;
    logic        r_lb;
    logic        r_ub;
    logic [23:1] r_addr;
    logic [15:0] r_din;

    // Sequencer state and the per-access latches.
    state_t            r_state;
    logic              r_busy;
    logic [2:0]        r_cnt;
    logic [23:1]       r_rd_addr;
    logic              r_rd_lb;
    logic              r_rd_ub;
    logic [15:0]       r_rdata;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [15:0]       r_wr_data;
    logic              r_wr_lb;
    logic              r_wr_ub;

    // Backing store; deliberately has no reset so contents survive rst.
    logic [15:0] r_mem [0:(1<<ADDR_W)-1];

    logic        w_wr_req;
    logic        w_rd_req;
    logic        w_rd_end;
    logic        w_rd_chg;
    logic        w_commit;
    logic [2:0]  w_lat;
    logic [15:0] w_mem_word;
    logic [15:0] w_rd_masked;
    logic        w_unused;

`ifdef SRAM_RESPONDER_CRE_EN
    logic        r_adv;
    logic        r_cre;
    logic [15:0] r_bcr;
    logic        r_wr_cre;
    logic [15:0] r_wr_cfg;
    logic        w_cre_cyc;

    assign w_cre_cyc = ~r_adv & r_cre;
    assign w_lat     = (r_bcr[2:0] != 3'd0) ? r_bcr[2:0] : LP_RD_LAT;
    assign w_commit  = (r_state == WR_COMMIT) && !r_wr_cre;
    assign w_unused  = ^{sram_clk, r_bcr[15:3]};
`else
    assign w_lat     = LP_RD_LAT;
    assign w_commit  = (r_state == WR_COMMIT);
    assign w_unused  = ^{sram_clk, sram_adv, sram_cre};
`endif

    // we=0 wins over oe=0, so a write request is checked first.
    assign w_wr_req    = ~r_ce & ~r_we;
    assign w_rd_req    = ~r_ce & r_we & ~r_oe;
    assign w_rd_end    = r_ce | r_oe | ~r_we;
    assign w_rd_chg    = (r_addr != r_rd_addr) || (r_lb != r_rd_lb) || (r_ub != r_rd_ub);
    assign w_mem_word  = r_mem[r_rd_addr[ADDR_W:1]];
    assign w_rd_masked = {r_rd_ub ? 8'h00 : w_mem_word[15:8],
                          r_rd_lb ? 8'h00 : w_mem_word[7:0]};

    // Bus is driven purely from the state register, so an async reset releases it at once.
    assign sram_data = (r_state == RD_DRIVE) ? r_rdata : 16'hzzzz;
    assign busy      = r_busy;

    // Input sample stage: reset to an idle (deasserted) bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ce   <= 1'b1;
            r_oe   <= 1'b1;
            r_we   <= 1'b1;
            r_lb   <= 1'b1;
            r_ub   <= 1'b1;
            r_addr <= '0;
            r_din  <= '0;
`ifdef SRAM_RESPONDER_CRE_EN
            r_adv  <= 1'b1;
            r_cre  <= 1'b0;
`endif
        end else begin
            r_ce   <= sram_ce;
            r_oe   <= sram_oe;
            r_we   <= sram_we;
            r_lb   <= sram_lb;
            r_ub   <= sram_ub;
            r_addr <= sram_addr;
            r_din  <= sram_data;
`ifdef SRAM_RESPONDER_CRE_EN
            r_adv  <= sram_adv;
            r_cre  <= sram_cre;
`endif
        end
    end

    // Access sequencer; busy is registered together with the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_cnt     <= 3'd0;
            r_rdata   <= 16'h0000;
            r_rd_addr <= '0;
            r_rd_lb   <= 1'b1;
            r_rd_ub   <= 1'b1;
            r_wr_addr <= '0;
            r_wr_data <= 16'h0000;
            r_wr_lb   <= 1'b1;
            r_wr_ub   <= 1'b1;
`ifdef SRAM_RESPONDER_CRE_EN
            r_bcr     <= 16'h0000;
            r_wr_cre  <= 1'b0;
            r_wr_cfg  <= 16'h0000;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_wr_req) begin
                        r_state   <= WR_HOLD;
                        r_busy    <= 1'b1;
                        r_wr_addr <= r_addr[ADDR_W:1];
                        r_wr_data <= r_din;
                        r_wr_lb   <= r_lb;
                        r_wr_ub   <= r_ub;
`ifdef SRAM_RESPONDER_CRE_EN
                        r_wr_cre  <= w_cre_cyc;
                        r_wr_cfg  <= r_addr[16:1];
`endif
                    end else if (w_rd_req) begin
                        r_state   <= RD_WAIT;
                        r_busy    <= 1'b1;
                        r_rd_addr <= r_addr;
                        r_rd_lb   <= r_lb;
                        r_rd_ub   <= r_ub;
                        r_cnt     <= w_lat - 3'd1;
                    end
                end
                RD_WAIT: begin
                    if (w_rd_end) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= 3'd0;
                    end else if (w_rd_chg) begin
                        r_rd_addr <= r_addr;
                        r_rd_lb   <= r_lb;
                        r_rd_ub   <= r_ub;
                        r_cnt     <= w_lat - 3'd1;
                    end else if (r_cnt == 3'd0) begin
                        r_state <= RD_DRIVE;
                        r_rdata <= w_rd_masked;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                RD_DRIVE: begin
                    if (w_rd_end) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_rd_chg) begin
                        r_state   <= RD_WAIT;
                        r_rd_addr <= r_addr;
                        r_rd_lb   <= r_lb;
                        r_rd_ub   <= r_ub;
                        r_cnt     <= w_lat - 3'd1;
                    end
                end
                WR_HOLD: begin
                    if (w_wr_req) begin
                        r_wr_addr <= r_addr[ADDR_W:1];
                        r_wr_data <= r_din;
                        r_wr_lb   <= r_lb;
                        r_wr_ub   <= r_ub;
`ifdef SRAM_RESPONDER_CRE_EN
                        r_wr_cre  <= w_cre_cyc;
                        r_wr_cfg  <= r_addr[16:1];
`endif
                    end else begin
                        r_state <= WR_COMMIT;
                    end
                end
                WR_COMMIT: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
`ifdef SRAM_RESPONDER_CRE_EN
                    if (r_wr_cre) begin
                        r_bcr <= r_wr_cfg;
                    end
`endif
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Byte-lane array write on commit; reset never touches the array.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            if (!r_wr_lb) begin
                r_mem[r_wr_addr][7:0] <= r_wr_data[7:0];
            end
            if (!r_wr_ub) begin
                r_mem[r_wr_addr][15:8] <= r_wr_data[15:8];
            end
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: scoreboard bench for sram_responder. Stimulus tasks push
// cycle-stamped expectations from a halfword-array reference model; a negedge
// monitor pops and compares them against the bus and busy.
`timescale 1ns/1ps
module tb_sram_responder;
    localparam int ADDR_W = 12;
    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        sram_clk, sram_adv, sram_cre, sram_ce, sram_oe, sram_we, sram_lb, sram_ub;
    logic [23:1] sram_addr;
    wire  [15:0] sram_data;
    logic        busy;
    logic        tb_drv;
    logic [15:0] tb_dout;

    assign sram_data = tb_drv ? tb_dout : 16'hzzzz;

    sram_responder #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .sram_clk(sram_clk), .sram_adv(sram_adv), .sram_cre(sram_cre),
        .sram_ce(sram_ce), .sram_oe(sram_oe), .sram_we(sram_we), .sram_lb(sram_lb),
        .sram_ub(sram_ub), .sram_addr(sram_addr), .sram_data(sram_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // kind 0: bus must equal val; kind 1: bus must not show val; kind 2: busy must equal val[0]
    typedef struct {
        int          cyc;
        int          kind;
        logic [15:0] val;
        string       name;
    } chk_t;

    chk_t        exp_q[$];
    chk_t        mon_e;
    logic [15:0] model_mem [int];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          lat = RD_LAT;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc <= cyc) begin
                mon_e = exp_q[i];
                exp_q.delete(i);
                checks++;
                case (mon_e.kind)
                    0: if (sram_data !== mon_e.val) begin
                        failures++;
                        $display("FAIL %s @%0d: bus=%h want=%h", mon_e.name, cyc, sram_data, mon_e.val);
                    end
                    1: if (sram_data === mon_e.val) begin
                        failures++;
                        $display("FAIL %s @%0d: bus=%h want released (not %h)", mon_e.name, cyc, sram_data, mon_e.val);
                    end
                    default: if (busy !== mon_e.val[0]) begin
                        failures++;
                        $display("FAIL %s @%0d: busy=%b want=%b", mon_e.name, cyc, busy, mon_e.val[0]);
                    end
                endcase
            end
        end
    end

    function automatic void expect_at(input int c, input int k, input logic [15:0] v, input string n);
        chk_t e;
        e.cyc = c; e.kind = k; e.val = v; e.name = n;
        exp_q.push_back(e);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle_pins();
        sram_ce = 1'b1; sram_oe = 1'b1; sram_we = 1'b1; sram_lb = 1'b1; sram_ub = 1'b1;
        sram_adv = 1'b1; sram_cre = 1'b0; tb_drv = 1'b0;
    endtask

    // Write cycle held for 'hold' clocks; a CRE cycle leaves the array model alone.
    task automatic do_write(input logic [22:0] a, input logic [15:0] d, input logic lb,
                            input logic ub, input int hold, input logic cre);
        int          idx;
        int          r;
        logic [15:0] old;
        idx = int'(a) % (1 << ADDR_W);
        sram_addr = a; tb_dout = d; tb_drv = 1'b1; sram_lb = lb; sram_ub = ub;
        sram_ce = 1'b0; sram_we = 1'b0;
        if (cre) begin
            sram_adv = 1'b0; sram_cre = 1'b1;
        end
        expect_at(cyc + 2, 2, 16'd1, "wr_busy");
        tick(hold);
        idle_pins();
        r = cyc;
        expect_at(r + 2, 2, 16'd1, "wr_commit_busy");
        expect_at(r + 3, 2, 16'd0, "wr_idle");
        if (!cre) begin
            old = model_mem.exists(idx) ? model_mem[idx] : 16'h0000;
            model_mem[idx] = {ub ? old[15:8] : d[15:8], lb ? old[7:0] : d[7:0]};
        end
        tick(3);
    endtask

    // Read: data expected exactly lat+1 cycles after the first edge that sees oe low.
    task automatic do_read(input logic [22:0] a, input logic lb, input logic ub, input int hold);
        int          idx;
        int          c;
        int          r;
        logic [15:0] w;
        logic [15:0] expv;
        idx  = int'(a) % (1 << ADDR_W);
        w    = model_mem[idx];
        expv = {ub ? 8'h00 : w[15:8], lb ? 8'h00 : w[7:0]};
        c = cyc;
        sram_addr = a; sram_lb = lb; sram_ub = ub; sram_we = 1'b1; sram_ce = 1'b0; sram_oe = 1'b0;
        if (expv != 16'h0000) expect_at(c + 1 + lat, 1, expv, "rd_early");
        expect_at(c + 1 + lat, 2, 16'd1, "rd_busy");
        for (int h = 0; h <= hold; h++) expect_at(c + 2 + lat + h, 0, expv, "rd_data");
        tick(2 + lat + hold);
        idle_pins();
        r = cyc;
        if (expv != 16'h0000) expect_at(r + 2, 1, expv, "rd_release");
        expect_at(r + 2, 2, 16'd0, "rd_idle");
        tick(3);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    logic [22:0] raddr [12];

    initial begin
        int c;
        int d;
        sram_clk = 1'b0; tb_dout = 16'h0000; sram_addr = '0;
        idle_pins();
        rst = 1'b0;
        #1 rst = 1'b1;
        tick(2);
        expect_at(cyc, 2, 16'd0, "reset_busy");
        tick(1);
        rst = 1'b0;
        tick(2);

        // basic write then read with exact latency
        do_write(23'h10, 16'hBEEF, 1'b0, 1'b0, 2, 1'b0);
        do_read(23'h10, 1'b0, 1'b0, 1);

        // upper-lane-disabled write merges with older data
        do_write(23'h20, 16'hAAAA, 1'b0, 1'b0, 1, 1'b0);
        do_write(23'h20, 16'h5511, 1'b0, 1'b1, 3, 1'b0);
        do_read(23'h20, 1'b0, 1'b0, 0);

        // both lanes disabled: commits nothing
        do_write(23'h20, 16'h0000, 1'b1, 1'b1, 2, 1'b0);
        do_read(23'h20, 1'b0, 1'b0, 0);

        // aliasing above ADDR_W, and a masked-lane read
        do_write(23'h1001, 16'h1234, 1'b0, 1'b0, 1, 1'b0);
        do_read(23'h1, 1'b0, 1'b0, 0);
        do_read(23'h10, 1'b1, 1'b0, 0);

        // address change during drive relatches with a fresh latency
        do_write(23'h11, 16'h1357, 1'b0, 1'b0, 1, 1'b0);
        c = cyc;
        sram_addr = 23'h10; sram_lb = 1'b0; sram_ub = 1'b0; sram_we = 1'b1; sram_ce = 1'b0; sram_oe = 1'b0;
        expect_at(c + 2 + lat, 0, model_mem[16], "rl_first");
        tick(3 + lat);
        d = cyc;
        sram_addr = 23'h11;
        expect_at(d + 1, 0, model_mem[16], "rl_old");
        for (int k = 1; k <= 2 + lat; k++) expect_at(d + k, 2, 16'd1, "rl_busy");
        expect_at(d + 1 + lat, 1, model_mem[17], "rl_early");
        expect_at(d + 2 + lat, 0, model_mem[17], "rl_new");
        tick(2 + lat);
        idle_pins();
        expect_at(cyc + 2, 2, 16'd0, "rl_idle");
        tick(3);

        // reset while driving releases the bus immediately
        c = cyc;
        sram_addr = 23'h10; sram_lb = 1'b0; sram_ub = 1'b0; sram_we = 1'b1; sram_ce = 1'b0; sram_oe = 1'b0;
        expect_at(c + 2 + lat, 0, model_mem[16], "rstr_drive");
        tick(3 + lat);
        rst = 1'b1;
        expect_at(cyc, 1, model_mem[16], "rstr_release");
        expect_at(cyc, 2, 16'd0, "rstr_busy");
        tick(2);
        idle_pins();
        tick(1);
        rst = 1'b0;
        tick(2);

        // reset during a held write discards it
        do_write(23'h5, 16'h0001, 1'b0, 1'b0, 1, 1'b0);
        sram_addr = 23'h5; tb_dout = 16'hFFFF; tb_drv = 1'b1; sram_lb = 1'b0; sram_ub = 1'b0;
        sram_ce = 1'b0; sram_we = 1'b0;
        tick(4);
        rst = 1'b1;
        expect_at(cyc, 2, 16'd0, "rstw_busy");
        tick(2);
        idle_pins();
        tick(1);
        rst = 1'b0;
        tick(2);
        do_read(23'h5, 1'b0, 1'b0, 0);

`ifdef SRAM_RESPONDER_CRE_EN
        // configuration write sets latency 5 and leaves the array alone
        do_write(23'h00005, 16'hDEAD, 1'b0, 1'b0, 2, 1'b1);
        lat = 5;
        do_read(23'h5, 1'b0, 1'b0, 0);
`endif

        // randomized traffic over a small address pool
        for (int i = 0; i < 12; i++) begin
            raddr[i] = 23'($urandom);
            do_write(raddr[i], 16'($urandom), 1'b0, 1'b0, int'($urandom_range(1, 3)), 1'b0);
        end
        for (int n = 0; n < 40; n++) begin
            int          k;
            logic [22:0] al;
            k  = int'($urandom_range(0, 11));
            al = raddr[k] ^ (23'($urandom) << ADDR_W);
            if ($urandom_range(0, 1) == 1)
                do_write(al, 16'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(1, 3)), 1'b0);
            else
                do_read(al, 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end

        tick(5);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: pending=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
